// File: rtl/reset_sequencer_if.sv
// Board reset controller bus: clock-wizard/button/SOC requests in,
// staged active-low resets and debug status out.
interface reset_sequencer_if;
  logic       pll_locked_i;
  logic       button_i;
  logic       soft_rst_req_i;
  logic       periph_rst_n_o;
  logic       mem_rst_n_o;
  logic       cpu_rst_n_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [2:0] rst_cause_o;

  modport master (
    output pll_locked_i,
    output button_i,
    output soft_rst_req_i,
    input  periph_rst_n_o,
    input  mem_rst_n_o,
    input  cpu_rst_n_o,
    input  ready_o,
    input  state_o,
    input  rst_cause_o
  );

  modport slave (
    input  pll_locked_i,
    input  button_i,
    input  soft_rst_req_i,
    output periph_rst_n_o,
    output mem_rst_n_o,
    output cpu_rst_n_o,
    output ready_o,
    output state_o,
    output rst_cause_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: filters PLL lock, debounces the button, and releases
// peripheral, memory and CPU resets in order after any reset event.
module reset_sequencer #(
  parameter int MIN_ASSERT_CYCLES  = 64,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int STAGE_DELAY_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  reset_sequencer_if.slave bus
);

  localparam int MAX_A = (MIN_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ?
                         MIN_ASSERT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > STAGE_DELAY_CYCLES) ?
                         MAX_A : STAGE_DELAY_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD         = 3'd0,
    WAIT_LOCK    = 3'd1,
    STAGE_PERIPH = 3'd2,
    STAGE_MEM    = 3'd3,
    RUN          = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] db_cnt;
  logic          lock_m, lock_s;
  logic          btn_m, btn_s;
  logic          btn_db, btn_db_q;
  logic          periph_q, mem_q, cpu_q, ready_q;
  logic [2:0]    cause;
  logic          pll_loss;
  logic          btn_rise;
  logic [2:0]    ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      lock_m <= bus.pll_locked_i;
      lock_s <= lock_m;
      btn_m  <= bus.button_i;
      btn_s  <= btn_m;
    end
  end

  // Count only while a level change is pending; a bounce back clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign pll_loss = !lock_s && (state == STAGE_PERIPH ||
                                state == STAGE_MEM ||
                                state == RUN);
  assign btn_rise = btn_db && !btn_db_q;
  assign ev = {bus.soft_rst_req_i, btn_rise, pll_loss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      cnt      <= '0;
      cause    <= 3'b000;
      periph_q <= 1'b0;
      mem_q    <= 1'b0;
      cpu_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      periph_q <= (state == STAGE_PERIPH) ||
                  (state == STAGE_MEM) || (state == RUN);
      mem_q    <= (state == STAGE_MEM) || (state == RUN);
      cpu_q    <= (state == RUN);
      ready_q  <= (state == RUN);
      if (|ev) begin
        state <= HOLD;
        cnt   <= '0;
        cause <= (state == HOLD) ? (cause | ev) : ev;
      end else begin
        unique case (state)
          HOLD: begin
            if (cnt == MIN_LAST && !btn_db) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt != MIN_LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (!lock_s) begin
              cnt <= '0;
            end else if (cnt == LOCK_LAST) begin
              state <= STAGE_PERIPH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STAGE_PERIPH: begin
            if (cnt == STAGE_LAST) begin
              state <= STAGE_MEM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STAGE_MEM: begin
            if (cnt == STAGE_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            cnt <= '0;
          end
          default: begin
            state <= HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.periph_rst_n_o = periph_q;
  assign bus.mem_rst_n_o    = mem_q;
  assign bus.cpu_rst_n_o    = cpu_q;
  assign bus.ready_o        = ready_q;
  assign bus.state_o        = state;
  assign bus.rst_cause_o    = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reset_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   hold_entries;
  logic [2:0] prev_state;

  reset_sequencer_if bus ();

  reset_sequencer #(
    .MIN_ASSERT_CYCLES (4),
    .LOCK_STABLE_CYCLES(8),
    .DEBOUNCE_CYCLES   (5),
    .STAGE_DELAY_CYCLES(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.state_o == 3'd0 && prev_state != 3'd0)
      hold_entries++;
    prev_state = bus.state_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.periph_rst_n_o;
      1:       return bus.mem_rst_n_o;
      2:       return bus.cpu_rst_n_o;
      3:       return bus.ready_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_rise(input int w, input int limit, output int k);
    k = 0;
    while (k < limit && sig(w) !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    if (sig(w) !== 1'b1) k = -1;
  endtask

  function automatic logic [3:0] rsts();
    return {bus.periph_rst_n_o, bus.mem_rst_n_o,
            bus.cpu_rst_n_o, bus.ready_o};
  endfunction

  initial begin
    int k;
    int t;
    int base;
    logic seen_hold;
    clk = 1'b0;
    rst_n = 1'b0;
    n_chk = 0;
    n_fail = 0;
    hold_entries = 0;
    prev_state = 3'd0;
    bus.pll_locked_i = 1'b1;
    bus.button_i = 1'b0;
    bus.soft_rst_req_i = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("por_state", bus.state_o, 3'd0);
    chk("por_rsts", rsts(), 4'b0000);
    chk("por_cause", bus.rst_cause_o, 3'b000);

    // 1: power-on sequence with lock held
    rst_n = 1'b1;
    wait_rise(0, 30, k);
    chk("t1_periph_window", (k >= 12 && k <= 15), 1);
    chk("t1_periph_at", k, 13);
    chk("t1_state_sp", bus.state_o, 3'd2);
    chk("t1_mem_low", bus.mem_rst_n_o, 1'b0);
    wait_rise(1, 10, k);
    chk("t1_mem_gap", k, 3);
    chk("t1_state_sm", bus.state_o, 3'd3);
    wait_rise(2, 10, k);
    chk("t1_cpu_gap", k, 3);
    chk("t1_ready", bus.ready_o, 1'b1);
    chk("t1_state_run", bus.state_o, 3'd4);
    chk("t1_cause", bus.rst_cause_o, 3'b000);

    // 2: one-cycle lock bounce at lock count 6
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_hold = 1'b0;
    t = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i >= 5 && bus.state_o == 3'd0) seen_hold = 1'b1;
      if (bus.periph_rst_n_o === 1'b1 && t < 0) t = i;
      if (i == 8) bus.pll_locked_i = 1'b0;
      if (i == 9) bus.pll_locked_i = 1'b1;
    end
    chk("t2_periph_at", t, 20);
    chk("t2_no_hold", seen_hold, 1'b0);
    chk("t2_run", bus.state_o, 3'd4);

    // 3: lock drop in RUN
    bus.pll_locked_i = 1'b0;
    @(negedge clk);
    bus.pll_locked_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_state_hold", bus.state_o, 3'd0);
    chk("t3_cause", bus.rst_cause_o, 3'b001);
    chk("t3_periph_lag", bus.periph_rst_n_o, 1'b1);
    @(negedge clk);
    chk("t3_rsts_low", rsts(), 4'b0000);
    wait_rise(0, 30, k);
    chk("t3_periph_at", k, 12);
    wait_rise(3, 20, k);
    chk("t3_ready_at", k, 6);
    chk("t3_cause_kept", bus.rst_cause_o, 3'b001);

    // soft request latency
    bus.soft_rst_req_i = 1'b1;
    @(negedge clk);
    bus.soft_rst_req_i = 1'b0;
    chk("soft_state", bus.state_o, 3'd0);
    chk("soft_cause", bus.rst_cause_o, 3'b100);
    chk("soft_lag", rsts(), 4'b1111);
    @(negedge clk);
    chk("soft_rsts_low", rsts(), 4'b0000);
    wait_rise(3, 40, k);
    chk("soft_ready_at", k, 18);

    // 4: soft pulse coincident with debounced button rise
    bus.button_i = 1'b1;
    repeat (7) @(negedge clk);
    chk("t4_pre_run", bus.state_o, 3'd4);
    bus.soft_rst_req_i = 1'b1;
    @(negedge clk);
    bus.soft_rst_req_i = 1'b0;
    chk("t4_state", bus.state_o, 3'd0);
    chk("t4_cause", bus.rst_cause_o, 3'b110);
    @(negedge clk);
    chk("t4_rsts_low", rsts(), 4'b0000);
    repeat (10) @(negedge clk);
    chk("t4_held_hold", bus.state_o, 3'd0);
    bus.button_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_release_hold", bus.state_o, 3'd0);
    wait_rise(3, 40, k);
    chk("t4_ready_at", k, 18);
    chk("t4_cause_kept", bus.rst_cause_o, 3'b110);

    // 5: bounces ignored, held press resets once
    base = hold_entries;
    for (int b = 0; b < 4; b++) begin
      bus.button_i = 1'b1;
      @(negedge clk);
      bus.button_i = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("t5_bounce_run", bus.state_o, 3'd4);
    chk("t5_bounce_ready", bus.ready_o, 1'b1);
    chk("t5_bounce_entries", hold_entries - base, 0);
    bus.button_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_held_state", bus.state_o, 3'd0);
    chk("t5_held_cause", bus.rst_cause_o, 3'b010);
    chk("t5_held_rsts", rsts(), 4'b0000);
    bus.button_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_release_hold", bus.state_o, 3'd0);
    k = 0;
    while (k < 30 && bus.state_o !== 3'd3) begin
      @(negedge clk);
      k++;
    end
    chk("t5_mem_stage_at", k, 14);
    chk("t5_entries", hold_entries - base, 1);
    chk("t5_cause_kept", bus.rst_cause_o, 3'b010);

    // 6: asynchronous reset in STAGE_MEM
    chk("t6_pre_periph", bus.periph_rst_n_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_state", bus.state_o, 3'd0);
    chk("t6_rsts", rsts(), 4'b0000);
    chk("t6_cause", bus.rst_cause_o, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
